// File: rtl/mem_bank_arbiter.sv
// Two-requester arbiter and sequencer for the shared 16-bit data-memory path.
// Optional feature macro: MEM_ARB_FIXED_PRIO_EN (requester 0 always wins; default is round-robin).
module mem_bank_arbiter #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RD_LAT   = 2,
    parameter int unsigned BANK_BIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              bank_sel,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_grant;
    logic                w_grant_id;
    logic                w_pick1;
    logic                w_cnt_load;
    logic                w_cnt_dec;
    logic                w_capture;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    logic                r_gnt0;
    logic                r_gnt1;
    logic                r_rvalid0;
    logic                r_rvalid1;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_bank_sel;
    logic                r_busy;
    logic                r_owner;
    logic                r_we;
    logic [CNT_W-1:0]    r_cnt;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign w_pick1 = ~req0;
`else
    logic r_last;
    // Round-robin: on a tie, grant whichever requester was not granted last.
    assign w_pick1 = (req0 && req1) ? ~r_last : req1;
`endif

    assign w_sel_we    = w_grant_id ? we1    : we0;
    assign w_sel_addr  = w_grant_id ? addr1  : addr0;
    assign w_sel_wdata = w_grant_id ? wdata1 : wdata0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_id  = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_grant     = 1'b1;
                    w_grant_id  = w_pick1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_we) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_load  = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Counter hits 0 in the cycle mem_rdata is valid; capture at its end.
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_rdata     <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_bank_sel  <= 1'b0;
            r_busy      <= 1'b0;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_gnt0    <= w_grant & ~w_grant_id;
            r_gnt1    <= w_grant & w_grant_id;
            r_mem_en  <= w_grant;
            r_mem_we  <= w_grant & w_sel_we;
            r_rvalid0 <= w_capture & ~r_owner;
            r_rvalid1 <= w_capture & r_owner;
            r_busy    <= (w_state_nxt != S_IDLE);
            if (w_grant) begin
                r_owner     <= w_grant_id;
                r_we        <= w_sel_we;
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
                r_bank_sel  <= w_sel_addr[BANK_BIT];
            end
            if (w_cnt_load) begin
                r_cnt <= CNT_W'(RD_LAT - 1);
            end else if (w_cnt_dec) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_capture) begin
                r_rdata <= mem_rdata;
            end
        end
    end

`ifndef MEM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_grant_id;
        end
    end
`endif

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign rdata     = r_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign bank_sel  = r_bank_sel;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Directed self-checking bench for mem_bank_arbiter; memory model returns addr ^ 16'h1224
// exactly RD_LAT=2 cycles after the mem_en cycle and 16'hDEAD at any other time.
module tb_mem_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, bank_sel, busy;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [1:0]  rd_v = 2'b00;
    logic [15:0] rd_a1 = '0, rd_a2 = '0;

    mem_bank_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(2), .BANK_BIT(15)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .bank_sel(bank_sel),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_v  <= {rd_v[0], mem_en & ~mem_we};
        rd_a1 <= mem_addr;
        rd_a2 <= rd_a1;
    end
    assign mem_rdata = rd_v[1] ? (rd_a2 ^ 16'h1224) : 16'hDEAD;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, bank_sel, busy} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000000",
                     {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, bank_sel, busy});
        end
        checks++;
        if ({mem_addr, mem_wdata, rdata} !== 48'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, rdata});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h8004; wdata0 = 16'hABCD;
        tick();
        checks++;
        if ({gnt0, gnt1, mem_en, mem_we, bank_sel, busy} !== 6'b101111) begin
            failures++;
            $display("FAIL wr_strobes got=%b exp=101111", {gnt0, gnt1, mem_en, mem_we, bank_sel, busy});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== {16'h8004, 16'hABCD}) begin
            failures++;
            $display("FAIL wr_addr_data got=%h_%h exp=8004_abcd", mem_addr, mem_wdata);
        end
        req0 = 1'b0; we0 = 1'b0;
        tick();
        checks++;
        if ({mem_en, mem_we, busy, bank_sel, mem_addr} !== {4'b0001, 16'h8004}) begin
            failures++;
            $display("FAIL wr_hold got=%b_%h exp=0001_8004", {mem_en, mem_we, busy, bank_sel}, mem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({rvalid0, rvalid1} !== 2'b00) begin
                failures++;
                $display("FAIL wr_no_rvalid cycle=%0d got=%b exp=00", i, {rvalid0, rvalid1});
            end
        end
    endtask

    task automatic test_single_read();
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0010;
        tick();
        checks++;
        if ({gnt0, gnt1, mem_en, mem_we, bank_sel} !== 5'b01100) begin
            failures++;
            $display("FAIL rd_issue got=%b exp=01100", {gnt0, gnt1, mem_en, mem_we, bank_sel});
        end
        req1 = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++;
            if ({rvalid0, rvalid1, busy} !== 3'b001) begin
                failures++;
                $display("FAIL rd_wait t+%0d got=%b exp=001", i, {rvalid0, rvalid1, busy});
            end
        end
        tick();
        checks++;
        if ({rvalid0, rvalid1, rdata} !== {2'b01, 16'h1234}) begin
            failures++;
            $display("FAIL rd_resp got=%b_%h exp=01_1234", {rvalid0, rvalid1}, rdata);
        end
        tick();
        checks++;
        if ({rvalid0, rvalid1, busy, rdata} !== {3'b000, 16'h1234}) begin
            failures++;
            $display("FAIL rd_after got=%b_%h exp=000_1234", {rvalid0, rvalid1, busy}, rdata);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_vec;
        logic [1:0] got_vec;
        int last_g;
        int n;
        last_g = -1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0200;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0300;
        for (int r = 0; r < 4; r++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_vec = 2'b01;
`else
            exp_vec = r[0] ? 2'b10 : 2'b01;
`endif
            n = 0;
            do begin
                tick();
                n++;
            end while (!(gnt0 || gnt1) && n < 20);
            got_vec = {gnt1, gnt0};
            checks++;
            if (got_vec !== exp_vec) begin
                failures++;
                $display("FAIL simul_order round=%0d got=%b exp=%b", r, got_vec, exp_vec);
            end
            if (r > 0) begin
                checks++;
                if (cyc - last_g != 5) begin
                    failures++;
                    $display("FAIL simul_spacing round=%0d got=%0d exp=5", r, cyc - last_g);
                end
            end
            last_g = cyc;
            if (got_vec[1]) req1 = 1'b0; else req0 = 1'b0;
            n = 0;
            do begin
                tick();
                n++;
            end while (!(got_vec[1] ? rvalid1 : rvalid0) && n < 10);
            checks++;
            if (n >= 10) begin
                failures++;
                $display("FAIL simul_rvalid_timeout round=%0d got=none exp=pulse", r);
            end
            req0 = 1'b1; req1 = 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL simul_idle got=%b exp=0", busy);
        end
    endtask

    task automatic test_req_while_busy();
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040;
        tick();
        checks++;
        if (gnt0 !== 1'b1) begin
            failures++;
            $display("FAIL busy_gnt0 got=%b exp=1", gnt0);
        end
        req0 = 1'b0;
        tick();
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h8020;
        tick();
        checks++;
        if ({gnt1, busy} !== 2'b01) begin
            failures++;
            $display("FAIL busy_blocked got=%b exp=01", {gnt1, busy});
        end
        tick();
        checks++;
        if ({gnt1, rvalid0, rdata} !== {2'b01, 16'h1264}) begin
            failures++;
            $display("FAIL busy_resp0 got=%b_%h exp=01_1264", {gnt1, rvalid0}, rdata);
        end
        tick();
        checks++;
        if ({gnt1, busy} !== 2'b00) begin
            failures++;
            $display("FAIL busy_idle got=%b exp=00", {gnt1, busy});
        end
        tick();
        checks++;
        if ({gnt1, mem_en, bank_sel, mem_addr} !== {3'b111, 16'h8020}) begin
            failures++;
            $display("FAIL busy_gnt1 got=%b_%h exp=111_8020", {gnt1, mem_en, bank_sel}, mem_addr);
        end
        req1 = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({rvalid1, rdata} !== {1'b1, 16'h9204}) begin
            failures++;
            $display("FAIL busy_resp1 got=%b_%h exp=1_9204", rvalid1, rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int en_cyc[$];
        logic [15:0] exp_wd [3];
        int pulses;
        exp_wd[0] = 16'h1111; exp_wd[1] = 16'h2222; exp_wd[2] = 16'h3333;
        pulses = 0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0100; wdata0 = 16'h1111;
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if (mem_we && !mem_en) begin
                failures++;
                $display("FAIL b2b_we_without_en cycle=%0d got=1 exp=0", i);
            end
            if (mem_en) begin
                checks++;
                if (pulses < 3 && mem_wdata !== exp_wd[pulses]) begin
                    failures++;
                    $display("FAIL b2b_wdata pulse=%0d got=%h exp=%h", pulses, mem_wdata, exp_wd[pulses]);
                end
                en_cyc.push_back(cyc);
                pulses++;
                if (pulses < 3) wdata0 = exp_wd[pulses];
                else begin
                    req0 = 1'b0; we0 = 1'b0;
                end
            end
        end
        checks++;
        if (pulses != 3) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=3", pulses);
        end else begin
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (en_cyc[k] - en_cyc[k-1] != 2) begin
                    failures++;
                    $display("FAIL b2b_spacing k=%0d got=%0d exp=2", k, en_cyc[k] - en_cyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h8030;
        tick();
        req1 = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, bank_sel, busy} !== 8'h00) begin
            failures++;
            $display("FAIL midrst_ctrl got=%b exp=00000000",
                     {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, bank_sel, busy});
        end
        checks++;
        if ({mem_addr, mem_wdata, rdata} !== 48'h0) begin
            failures++;
            $display("FAIL midrst_data got=%h exp=0", {mem_addr, mem_wdata, rdata});
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({rvalid0, rvalid1, busy} !== 3'b000) begin
                failures++;
                $display("FAIL midrst_after cycle=%0d got=%b exp=000", i, {rvalid0, rvalid1, busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_simultaneous();
        test_req_while_busy();
        test_back_to_back();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
